// File: rtl/mmio_console.sv
// Memory-mapped console/exit peripheral: PUTC bytes go through a FIFO to a valid/ready stream.
// Exit indication is sticky and rises only once every buffered byte has drained.
module mmio_console #(
  parameter logic [31:0] PUTC_ADDR = 32'h8000001c,
  parameter logic [31:0] STAT_ADDR = 32'h80000020,
  parameter logic [31:0] EXIT_ADDR = 32'h8000002c,
  parameter int          DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       wr_en,
  input  logic [31:0]                wr_addr,
  input  logic [31:0]                wr_data,
  input  logic [3:0]                 wr_strb,
  output logic                       wr_hit,
  output logic                       wr_stall,
  input  logic                       rd_en,
  input  logic [31:0]                rd_addr,
  output logic                       rd_hit,
  output logic                       rd_resp,
  output logic [31:0]                rd_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [7:0]                 tx_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       exit_valid,
  output logic [31:0]                exit_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty;
  logic            putc_wr, stat_wr, exit_wr;
  logic            push, pop, exit_take;
  logic [31:0]     status;
  logic            unused_strb;

  assign unused_strb = ^wr_strb[3:1];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  assign putc_wr = wr_en && (wr_addr == PUTC_ADDR);
  assign stat_wr = wr_en && (wr_addr == STAT_ADDR);
  assign exit_wr = wr_en && (wr_addr == EXIT_ADDR);
  assign wr_hit  = putc_wr || stat_wr || exit_wr;

  // A full FIFO stalls even if the head pops this cycle; the write lands next cycle.
  assign wr_stall  = putc_wr && (state_q == RUN) && full;
  assign push      = putc_wr && (state_q == RUN) && !full && wr_strb[0];
  assign exit_take = exit_wr && (state_q == RUN);

  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;

  assign rd_hit     = rd_en && (rd_addr == STAT_ADDR);
  assign exit_valid = (state_q == DONE);
  assign status     = {16'h0, 8'(level), 4'h0, state_q, full, empty};

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (exit_take) state_d = DRAIN;
      DRAIN:   if (empty)     state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q   <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      exit_code <= '0;
      rd_resp   <= 1'b0;
      rd_data   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (exit_take) exit_code <= wr_data;
      rd_resp <= rd_hit;
      if (rd_hit) rd_data <= status;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console with hand-computed expectations.
module tb_mmio_console;

  localparam logic [31:0] PUTC = 32'h8000001c;
  localparam logic [31:0] STAT = 32'h80000020;
  localparam logic [31:0] EXIT = 32'h8000002c;

  logic        clk = 1'b0;
  logic        resetb, wr_en, rd_en, tx_ready;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;
  logic        wr_hit, wr_stall, rd_hit, rd_resp, tx_valid, exit_valid;
  logic [31:0] rd_data, exit_code;
  logic [7:0]  tx_data;
  logic [4:0]  level;

  int checks = 0;
  int failures = 0;

  mmio_console dut (
    .clk(clk), .resetb(resetb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_hit(wr_hit), .wr_stall(wr_stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_resp(rd_resp), .rd_data(rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .level(level), .exit_valid(exit_valid), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic putc_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr(PUTC, 32'(base) + 32'(i), 4'h1);
      tick();
    end
    idle();
  endtask

  task automatic drain_all();
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) tick();
    chk("drain_done", 32'(level), 32'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    idle();
    tx_ready = 1'b0;
    resetb   = 1'b1;
    tick(); tick();
    resetb = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_exit_valid", 32'(exit_valid), 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_rd_resp", 32'(rd_resp), 0);
    chk("rst_rd_data", rd_data, 0);

    // Two characters with a ready sink
    tx_ready = 1'b1;
    wr(PUTC, 32'h48, 4'h1);
    #1;
    chk("h_hit", 32'(wr_hit), 1);
    chk("h_stall", 32'(wr_stall), 0);
    tick();
    chk("h_level", 32'(level), 1);
    chk("h_data", 32'(tx_data), 32'h48);
    wr(PUTC, 32'h69, 4'h1);
    #1;
    chk("i_stall", 32'(wr_stall), 0);
    tick();
    idle();
    chk("i_level", 32'(level), 1);
    chk("i_data", 32'(tx_data), 32'h69);
    tick();
    chk("hi_empty", 32'(level), 0);
    chk("hi_tx_valid", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // Byte strobe 0 on PUTC: hit, no push
    wr(PUTC, 32'h77, 4'h2);
    #1;
    chk("strb0_hit", 32'(wr_hit), 1);
    chk("strb0_stall", 32'(wr_stall), 0);
    tick();
    idle();
    chk("strb0_level", 32'(level), 0);

    // Fill to 16 and stall the 17th write
    putc_n(16, 8'h10);
    chk("full_level", 32'(level), 16);
    wr(PUTC, 32'h99, 4'h1);
    #1;
    chk("full_stall", 32'(wr_stall), 1);
    tick();
    chk("full_hold_level", 32'(level), 16);
    chk("full_hold_stall", 32'(wr_stall), 1);
    tx_ready = 1'b1;
    #1;
    chk("pop_cycle_stall", 32'(wr_stall), 1);
    tick();
    tx_ready = 1'b0;
    chk("after_pop_level", 32'(level), 15);
    chk("after_pop_head", 32'(tx_data), 32'h11);
    #1;
    chk("accept_stall", 32'(wr_stall), 0);
    tick();
    idle();
    chk("accept_level", 32'(level), 16);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_byte%0d", i), 32'(tx_data), (i < 15) ? 32'(8'h11 + i) : 32'h99);
      tick();
    end
    tx_ready = 1'b0;
    chk("drain16_level", 32'(level), 0);

    // Status with 5 buffered bytes in RUN
    putc_n(5, 8'h30);
    rd_en = 1'b1; rd_addr = STAT;
    #1;
    chk("stat_rd_hit", 32'(rd_hit), 1);
    tick();
    idle();
    chk("stat5_resp", 32'(rd_resp), 1);
    chk("stat5_data", rd_data, 32'h00000500);
    tick();
    chk("stat_resp_drop", 32'(rd_resp), 0);
    chk("stat_data_hold", rd_data, 32'h00000500);
    drain_all();

    // Exit waits for drain
    putc_n(3, 8'h50);
    wr(EXIT, 32'h2a, 4'h0);
    tick();
    idle();
    tick();
    chk("drain_no_exit", 32'(exit_valid), 0);
    chk("drain_level", 32'(level), 3);
    tx_ready = 1'b1;
    tick(); tick(); tick();
    chk("drained_level", 32'(level), 0);
    chk("drained_no_exit_yet", 32'(exit_valid), 0);
    tick();
    chk("exit_valid", 32'(exit_valid), 1);
    chk("exit_code", exit_code, 32'h2a);

    // Accesses in DONE are ignored
    wr(PUTC, 32'h41, 4'h1);
    #1;
    chk("done_putc_hit", 32'(wr_hit), 1);
    chk("done_putc_stall", 32'(wr_stall), 0);
    tick();
    chk("done_no_push", 32'(level), 0);
    wr(EXIT, 32'h5, 4'hf);
    #1;
    chk("done_exit_hit", 32'(wr_hit), 1);
    chk("done_exit_stall", 32'(wr_stall), 0);
    tick();
    idle();
    chk("done_code_kept", exit_code, 32'h2a);
    chk("done_sticky", 32'(exit_valid), 1);
    rd_en = 1'b1; rd_addr = STAT;
    tick();
    idle();
    chk("stat_done", rd_data, 32'h00000009);

    // Reset mid-drain
    tx_ready = 1'b0;
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    putc_n(4, 8'h60);
    wr(EXIT, 32'h7, 4'hf);
    tick();
    idle();
    rd_en = 1'b1; rd_addr = STAT;
    tick();
    idle();
    chk("stat_drain", rd_data, 32'h00000404);
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_exit", 32'(exit_valid), 0);
    rd_en = 1'b1; rd_addr = STAT;
    tick();
    idle();
    chk("mid_rst_state", rd_data, 32'h00000001);
    rd_en = 1'b1; rd_addr = 32'h80000000;
    #1;
    chk("miss_rd_hit", 32'(rd_hit), 0);
    tick();
    idle();
    chk("miss_rd_resp", 32'(rd_resp), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
